// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
package mod_n_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..v-1 (0 for v <= 1).
    function automatic int clog2(input longint unsigned v);
        int             r;
        longint unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle of the modulo-N counter.
// master drives controls and observes status; slave is the counter itself.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             i_en;
    logic             i_up_dn;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic             i_clr_flag;
    logic [WIDTH-1:0] o_q;
    logic             o_tc;
    logic             o_wrap;
    logic             o_wrap_flag;

    modport master (
        output i_en, i_up_dn, i_load, i_load_val, i_clr_flag,
        input  o_q, o_tc, o_wrap, o_wrap_flag
    );

    modport slave (
        input  i_en, i_up_dn, i_load, i_load_val, i_clr_flag,
        output o_q, o_tc, o_wrap, o_wrap_flag
    );
endinterface

// File: rtl/mod_n_updown_counter_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE qualified enables.
// The phase only moves on en=1, so gaps in en stretch the period.
module clk_en_prescaler
    import mod_n_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_sync_clr,
    output logic o_tick
);
    // PRESCALE=1 still gets a 1-bit phase that simply stays at 0.
    localparam int            PW   = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_phase;
    logic          w_last;

    assign w_last = (r_phase == LAST);
    assign o_tick = i_en & w_last;

    // Phase counter: restart on sync clear, advance and wrap on enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_phase <= '0;
        else if (i_sync_clr)
            r_phase <= '0;
        else if (i_en)
            r_phase <= w_last ? '0 : r_phase + PW'(1);
    end
endmodule

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with load, prescaler, cascade
// carry (tc) and wrap pulse/sticky flag.
module mod_n_updown_counter
    import mod_n_updown_counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int              PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_n_updown_counter_if.slave bus
);
    // Terminal value held in WIDTH bits so MODULUS = 2**WIDTH maps to all-ones.
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

    logic             w_tick;
    logic             w_at_end;
    logic             w_tc;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_wrap_flag;

    clk_en_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .i_en       (bus.i_en),
        .i_sync_clr (bus.i_load),
        .o_tick     (w_tick)
    );

    assign w_at_end = (bus.i_up_dn == DIR_UP) ? (r_q == TOP_VAL) : (r_q == '0);
    assign w_tc     = w_tick & w_at_end;
    // Out-of-range loads clamp to the top of the range.
    assign w_load_q = (bus.i_load_val > TOP_VAL) ? TOP_VAL : bus.i_load_val;

    // Count register and wrap pulse: load beats count step beats hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (bus.i_load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            r_wrap <= w_at_end;
            if (bus.i_up_dn == DIR_UP)
                r_q <= w_at_end ? '0 : r_q + WIDTH'(1);
            else
                r_q <= w_at_end ? TOP_VAL : r_q - WIDTH'(1);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Sticky wrap flag: a wrap on this edge wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wrap_flag <= 1'b0;
        else if (w_tc && !bus.i_load)
            r_wrap_flag <= 1'b1;
        else if (bus.i_clr_flag)
            r_wrap_flag <= 1'b0;
    end

    assign bus.o_q         = r_q;
    assign bus.o_tc        = w_tc;
    assign bus.o_wrap      = r_wrap;
    assign bus.o_wrap_flag = r_wrap_flag;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: stimulus pushes the outputs expected in the cycle it
// drives; a monitor samples on the falling edge and compares.
module tb_mod_n_updown_counter;

    typedef struct {
        string      nm;
        int         dut;
        logic [7:0] q;
        logic       tc;
        logic       wrap;
        logic       flag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter_if #(.WIDTH(4)) ifa ();
    mod_n_updown_counter_if #(.WIDTH(4)) ifb ();
    mod_n_updown_counter_if #(.WIDTH(4)) ifc ();
    mod_n_updown_counter_if #(.WIDTH(4)) ifd ();

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (.clk(clk), .reset(reset), .bus(ifb));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_c (.clk(clk), .reset(reset), .bus(ifc));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_d (.clk(clk), .reset(reset), .bus(ifd));

    // Cascade: tens stage enabled by the units stage carry.
    assign ifd.i_en = ifc.o_tc;

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected before the next rising edge.
    task automatic drv(input int dut, input string nm, input logic rst, input logic en,
                       input logic up, input logic ld, input logic [3:0] lv, input logic clr,
                       input logic [7:0] eq, input logic etc, input logic ew, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        case (dut)
            0: begin ifa.i_en = en; ifa.i_up_dn = up; ifa.i_load = ld; ifa.i_load_val = lv; ifa.i_clr_flag = clr; end
            1: begin ifb.i_en = en; ifb.i_up_dn = up; ifb.i_load = ld; ifb.i_load_val = lv; ifb.i_clr_flag = clr; end
            default: begin ifc.i_en = en; ifc.i_up_dn = up; ifc.i_load = ld; ifc.i_load_val = lv; ifc.i_clr_flag = clr; end
        endcase
        e.nm = nm; e.dut = dut; e.q = eq; e.tc = etc; e.wrap = ew; e.flag = ef;
        sbq.push_back(e);
    endtask

    // Monitor: compare whatever is queued against the sampled outputs.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       atc, aw, af;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.dut)
                    0: begin aq = {4'h0, ifa.o_q}; atc = ifa.o_tc; aw = ifa.o_wrap; af = ifa.o_wrap_flag; end
                    1: begin aq = {4'h0, ifb.o_q}; atc = ifb.o_tc; aw = ifb.o_wrap; af = ifb.o_wrap_flag; end
                    default: begin aq = {ifd.o_q, ifc.o_q}; atc = ifd.o_tc; aw = ifd.o_wrap; af = ifd.o_wrap_flag; end
                endcase
                n_vec++;
                if (aq !== e.q || atc !== e.tc || aw !== e.wrap || af !== e.flag) begin
                    n_err++;
                    $display("FAIL %s @%0t: got q=%h tc=%b wrap=%b flag=%b, want q=%h tc=%b wrap=%b flag=%b",
                             e.nm, $time, aq, atc, aw, af, e.q, e.tc, e.wrap, e.flag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", sbq.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        ifa.i_en = 0; ifa.i_up_dn = 1; ifa.i_load = 0; ifa.i_load_val = '0; ifa.i_clr_flag = 0;
        ifb.i_en = 0; ifb.i_up_dn = 1; ifb.i_load = 0; ifb.i_load_val = '0; ifb.i_clr_flag = 0;
        ifc.i_en = 0; ifc.i_up_dn = 1; ifc.i_load = 0; ifc.i_load_val = '0; ifc.i_clr_flag = 0;
        ifd.i_up_dn = 1; ifd.i_load = 0; ifd.i_load_val = '0; ifd.i_clr_flag = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1. count to 5, then async reset mid-count
        for (int k = 0; k < 5; k++)
            drv(0, "reset_precount", 0, 1, 1, 0, 4'd0, 0, 8'(k), 0, 0, 0);
        drv(0, "reset_async", 1, 1, 1, 0, 4'd0, 0, 8'd0, 0, 0, 0);

        // 2. up count from 0 after release, wrap at 9
        for (int k = 0; k < 10; k++)
            drv(0, "up_run", 0, 1, 1, 0, 4'd0, 0, 8'(k), (k == 9), 0, 0);
        drv(0, "up_wrap", 0, 1, 1, 0, 4'd0, 0, 8'd0, 0, 1, 1);
        drv(0, "up_after", 0, 1, 1, 0, 4'd0, 0, 8'd1, 0, 0, 1);

        // 3. clamp load 12 -> 9 (also clearing flag), count down, wrap to 9
        drv(0, "load_clamp", 0, 1, 0, 1, 4'd12, 1, 8'd2, 0, 0, 1);
        for (int k = 9; k >= 0; k--)
            drv(0, "down_run", 0, 1, 0, 0, 4'd0, 0, 8'(k), (k == 0), 0, 0);
        drv(0, "down_wrap", 0, 1, 0, 0, 4'd0, 0, 8'd9, 0, 1, 1);

        // 6. flag race: wrap and clear on the same edge
        drv(0, "flag_clr", 0, 0, 0, 0, 4'd0, 1, 8'd8, 0, 0, 1);
        drv(0, "flag_cleared", 0, 0, 0, 0, 4'd0, 0, 8'd8, 0, 0, 0);
        drv(0, "race_load9", 0, 0, 1, 1, 4'd9, 0, 8'd8, 0, 0, 0);
        drv(0, "race_edge", 0, 1, 1, 0, 4'd0, 1, 8'd9, 1, 0, 0);
        drv(0, "race_set_wins", 0, 0, 1, 0, 4'd0, 1, 8'd0, 0, 1, 1);
        drv(0, "race_clr_alone", 0, 0, 1, 0, 4'd0, 0, 8'd0, 0, 0, 0);

        // 4. prescaler 3, load restarts phase, en=0 holds
        drv(1, "pre_p0", 0, 1, 1, 0, 4'd0, 0, 8'd0, 0, 0, 0);
        drv(1, "pre_p1", 0, 1, 1, 0, 4'd0, 0, 8'd0, 0, 0, 0);
        drv(1, "pre_p2", 0, 1, 1, 0, 4'd0, 0, 8'd0, 0, 0, 0);
        drv(1, "pre_step1", 0, 1, 1, 0, 4'd0, 0, 8'd1, 0, 0, 0);
        drv(1, "pre_step1", 0, 1, 1, 0, 4'd0, 0, 8'd1, 0, 0, 0);
        drv(1, "pre_step1", 0, 1, 1, 0, 4'd0, 0, 8'd1, 0, 0, 0);
        drv(1, "pre_step2", 0, 1, 1, 0, 4'd0, 0, 8'd2, 0, 0, 0);
        drv(1, "pre_midload", 0, 1, 1, 1, 4'd5, 0, 8'd2, 0, 0, 0);
        drv(1, "pre_ld_p0", 0, 1, 1, 0, 4'd0, 0, 8'd5, 0, 0, 0);
        drv(1, "pre_hold", 0, 0, 1, 0, 4'd0, 0, 8'd5, 0, 0, 0);
        drv(1, "pre_hold", 0, 0, 1, 0, 4'd0, 0, 8'd5, 0, 0, 0);
        drv(1, "pre_ld_p1", 0, 1, 1, 0, 4'd0, 0, 8'd5, 0, 0, 0);
        drv(1, "pre_ld_p2", 0, 1, 1, 0, 4'd0, 0, 8'd5, 0, 0, 0);
        drv(1, "pre_load_noen", 0, 0, 1, 1, 4'd9, 0, 8'd6, 0, 0, 0);
        drv(1, "pre_tc_p0", 0, 1, 1, 0, 4'd0, 0, 8'd9, 0, 0, 0);
        drv(1, "pre_tc_p1", 0, 1, 1, 0, 4'd0, 0, 8'd9, 0, 0, 0);
        drv(1, "pre_tc_p2", 0, 1, 1, 0, 4'd0, 0, 8'd9, 1, 0, 0);
        drv(1, "pre_wrap", 0, 0, 1, 0, 4'd0, 0, 8'd0, 0, 1, 1);

        // 5. BCD cascade: 100 enables return both stages to 0
        for (int i = 0; i <= 100; i++)
            drv(2, "cascade", 0, (i < 100), 1, 0, 4'd0, 0,
                {4'((i / 10) % 10), 4'(i % 10)}, (i == 99), (i == 100), (i == 100));

        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries never compared, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
